mybus_initiator: RTL and testbench

//  Initiator (master) end of the in_MyBus interface. It drives start/data and consumes ready/dataReady

---
 rtl/mybus_pkg.sv | 16 +
 rtl/in_MyBus.sv | 12 +
 rtl/mybus_echo_chk.sv | 48 ++++
 rtl/mybus_initiator.sv | 159 +++++++++++++++
 tb/tb_mybus_initiator.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mybus_pkg.sv
// mybus_pkg: shared types and default burst/timeout constants for the in_MyBus initiator
// and its responder bench.
package mybus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER,
    ST_DRAIN,
    ST_DONE
  } mybus_init_st_t;

  localparam int MYBUS_BURST_LEN   = 8;
  localparam int MYBUS_TIMEOUT_CYC = 16;

endpackage

// File: rtl/in_MyBus.sv
// in_MyBus: single-bit start/ready handshake plus serial data with a registered echo.
interface in_MyBus;

  logic start;
  logic data;
  logic ready;
  logic dataReady;

  modport M (output start, output data, input ready, input dataReady);
  modport S (input start, input data, output ready, output dataReady);

endinterface

// File: rtl/mybus_echo_chk.sv
// mybus_echo_chk: remembers the bit sent last cycle and counts echo mismatches,
// saturating at BURST_LEN.
module mybus_echo_chk #(
  parameter int BURST_LEN = 8,
  parameter int CNT_W     = $clog2(BURST_LEN + 1)
) (
  input  logic             ck,
  input  logic             arst,
  input  logic             clr,
  input  logic             en,
  input  logic             sent_bit,
  input  logic             echo_bit,
  output logic [CNT_W-1:0] mismatch
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN);

  logic             exp_q, exp_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The echo of a bit arrives one cycle after it was sent, so compare against the held copy.
  always_comb begin
    exp_d = sent_bit;
    vld_d = en;
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (vld_q && (echo_bit != exp_q) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      exp_q <= 1'b0;
      vld_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      exp_q <= exp_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  assign mismatch = cnt_q;

endmodule

// File: rtl/mybus_initiator.sv
// mybus_initiator: in_MyBus initiator; handshakes start/ready, serialises a burst LSB first and
// checks the registered echo. Define MYBUS_INIT_STATS_EN to build the burst/error statistics counters.
module mybus_initiator
  import mybus_pkg::*;
#(
  parameter int BURST_LEN   = MYBUS_BURST_LEN,
  parameter int TIMEOUT_CYC = MYBUS_TIMEOUT_CYC,
  localparam int CNT_W      = $clog2(BURST_LEN + 1)
) (
  input  logic                 ck,
  input  logic                 arst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [BURST_LEN-1:0] req_data,
  output logic                 busy,
  output logic                 rsp_done,
  output logic                 rsp_timeout,
  output logic [CNT_W-1:0]     rsp_mismatch,
  output logic [31:0]          stat_bursts,
  output logic [31:0]          stat_errs,
  in_MyBus.M                   uout_MyBusM
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYC);
  localparam int BIT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BURST_LEN - 1);

  mybus_init_st_t       state_q, state_d;
  logic [BURST_LEN-1:0] shreg_q, shreg_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic                 timeout_q, timeout_d;
  logic                 accept;
  logic                 start;
  logic                 data;
  logic [CNT_W-1:0]     mismatch;

  // Bus outputs decode from registered state only; ready/dataReady steer transitions, never outputs.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    wait_d    = wait_q;
    bit_d     = bit_q;
    timeout_d = timeout_q;
    accept    = 1'b0;
    req_ready = 1'b0;
    start     = 1'b0;
    data      = 1'b0;
    rsp_done  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept    = 1'b1;
          shreg_d   = req_data;
          timeout_d = 1'b0;
          wait_d    = '0;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        start = 1'b1;
        if (uout_MyBusM.ready) begin
          bit_d   = '0;
          state_d = ST_XFER;
        end else if (wait_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_XFER: begin
        data    = shreg_q[0];
        shreg_d = shreg_q >> 1;
        if (bit_q == BIT_LAST) begin
          state_d = ST_DRAIN;
        end else begin
          bit_d = bit_q + BIT_W'(1);
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE: begin
        rsp_done = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      wait_q    <= '0;
      bit_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      wait_q    <= wait_d;
      bit_q     <= bit_d;
      timeout_q <= timeout_d;
    end
  end

  mybus_echo_chk #(
    .BURST_LEN (BURST_LEN),
    .CNT_W     (CNT_W)
  ) u_echo_chk (
    .ck       (ck),
    .arst     (arst),
    .clr      (accept),
    .en       (state_q == ST_XFER),
    .sent_bit (data),
    .echo_bit (uout_MyBusM.dataReady),
    .mismatch (mismatch)
  );

  assign busy              = (state_q != ST_IDLE);
  assign rsp_timeout       = rsp_done & timeout_q;
  assign rsp_mismatch      = rsp_done ? mismatch : '0;
  assign uout_MyBusM.start = start;
  assign uout_MyBusM.data  = data;

`ifdef MYBUS_INIT_STATS_EN
  logic [31:0] bursts_q, bursts_d;
  logic [31:0] errs_q, errs_d;

  always_comb begin
    bursts_d = bursts_q;
    errs_d   = errs_q;
    if (rsp_done) begin
      bursts_d = bursts_q + 32'd1;
      if (timeout_q || (mismatch != '0)) begin
        errs_d = errs_q + 32'd1;
      end
    end
  end

  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      bursts_q <= '0;
      errs_q   <= '0;
    end else begin
      bursts_q <= bursts_d;
      errs_q   <= errs_d;
    end
  end

  assign stat_bursts = bursts_q;
  assign stat_errs   = errs_q;
`else
  assign stat_bursts = '0;
  assign stat_errs   = '0;
`endif

endmodule

// File: tb/tb_mybus_initiator.sv
// tb_mybus_initiator: drives mybus_initiator against a configurable echo responder and compares
// every cycle with a burst-level schedule model; honours MYBUS_INIT_STATS_EN like the design.
module tb_mybus_initiator;
  import mybus_pkg::*;

  localparam int L     = MYBUS_BURST_LEN;
  localparam int TO    = MYBUS_TIMEOUT_CYC;
  localparam int CNT_W = $clog2(L + 1);

  logic             ck = 1'b0;
  logic             arst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [L-1:0]     req_data = '0;
  logic             busy;
  logic             rsp_done;
  logic             rsp_timeout;
  logic [CNT_W-1:0] rsp_mismatch;
  logic [31:0]      stat_bursts;
  logic [31:0]      stat_errs;

  in_MyBus bus ();

  mybus_initiator dut (
    .ck           (ck),
    .arst         (arst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_data     (req_data),
    .busy         (busy),
    .rsp_done     (rsp_done),
    .rsp_timeout  (rsp_timeout),
    .rsp_mismatch (rsp_mismatch),
    .stat_bursts  (stat_bursts),
    .stat_errs    (stat_errs),
    .uout_MyBusM  (bus)
  );

  always #5 ck = ~ck;

  int n_pass  = 0;
  int n_total = 0;

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic failNow(input string nm);
    n_total++;
    $display("[TB] FAIL %s: bound expired at %0t", nm, $time);
  endtask

  // Responder settings: ready appears resp_d cycles into REQ (0 = never); flip_mask corrupts echoes.
  int           resp_d = 1;
  logic [L-1:0] flip_mask = '0;
  int           sc = 0;

  typedef struct {
    bit start;
    bit data;
    bit busy;
    bit done;
    bit tmo;
    int mm;
    bit flip;
  } exp_t;

  exp_t cur;
  exp_t q[$];
  int   m_bursts = 0;
  int   m_errs   = 0;

  function automatic exp_t idleRec();
    exp_t r;
    r = '{default: 0};
    return r;
  endfunction

  // Whole-burst schedule from the accept: REQ until ready or timeout, L data bits, drain, done.
  task automatic modelAccept();
    exp_t r;
    int   reqs;
    bit   to;
    to   = (resp_d == 0) || (resp_d > TO - 1);
    reqs = to ? TO : resp_d + 1;
    for (int k = 0; k < reqs; k++) begin
      r = idleRec(); r.busy = 1; r.start = 1; q.push_back(r);
    end
    if (!to) begin
      for (int i = 0; i < L; i++) begin
        r = idleRec(); r.busy = 1; r.data = req_data[i]; r.flip = flip_mask[i]; q.push_back(r);
      end
      r = idleRec(); r.busy = 1; q.push_back(r);
    end
    r = idleRec(); r.busy = 1; r.done = 1; r.tmo = to;
    r.mm = to ? 0 : $countones(flip_mask);
    q.push_back(r);
  endtask

  initial cur = idleRec();

  always @(posedge ck or posedge arst) begin
    int sc_n;
    if (arst) begin
      q.delete();
      cur = idleRec();
      sc = 0;
      m_bursts = 0;
      m_errs = 0;
      bus.ready <= 1'b0;
      bus.dataReady <= 1'b0;
    end else begin
      sc_n = bus.start ? sc + 1 : 0;
      bus.ready <= bus.start && (resp_d != 0) && (sc_n >= resp_d);
      bus.dataReady <= bus.data ^ cur.flip;
      sc = sc_n;
      if (cur.done) begin
        m_bursts++;
        if (cur.tmo || cur.mm > 0) m_errs++;
      end
      if (!cur.busy && req_valid) modelAccept();
      cur = (q.size() != 0) ? q.pop_front() : idleRec();
    end
  end

  always @(negedge ck) begin
    if (!arst) begin
      checkOutput("req_ready", req_ready, !cur.busy);
      checkOutput("busy", busy, cur.busy);
      checkOutput("start", bus.start, cur.start);
      checkOutput("data", bus.data, cur.data);
      checkOutput("rsp_done", rsp_done, cur.done);
      checkOutput("rsp_timeout", rsp_timeout, cur.tmo);
      checkOutput("rsp_mismatch", rsp_mismatch, cur.mm);
`ifdef MYBUS_INIT_STATS_EN
      checkOutput("stat_bursts", stat_bursts, m_bursts);
      checkOutput("stat_errs", stat_errs, m_errs);
`else
      checkOutput("stat_bursts", stat_bursts, 0);
      checkOutput("stat_errs", stat_errs, 0);
`endif
    end
  end

  // One directed burst; results are relative to the accept cycle (n = 0).
  task automatic applyStimulus(input logic [L-1:0] dat, input int d, input logic [L-1:0] mask,
                               input bit hold, output int done_n, output logic tmo,
                               output logic [CNT_W-1:0] mm, output int start_n,
                               output logic [L-1:0] bits, output bit data_seen);
    done_n = -1; tmo = 0; mm = '0; start_n = 0; bits = '0; data_seen = 0;
    @(posedge ck); #1;
    req_data = dat; resp_d = d; flip_mask = mask; req_valid = 1'b1;
    for (int n = 0; n <= 40 && done_n < 0; n++) begin
      if (n > 0) begin
        @(posedge ck); #1;
        if (!hold) req_valid = 1'b0;
      end
      @(negedge ck);
      if (bus.start) start_n++;
      if (bus.data) data_seen = 1;
      if (n >= d + 2 && n < d + 2 + L) bits[n-d-2] = bus.data;
      if (rsp_done) begin
        done_n = n; tmo = rsp_timeout; mm = rsp_mismatch;
      end
    end
    if (done_n < 0) failNow("done_wait");
  endtask

  task automatic waitIdle();
    int w;
    w = 0;
    while ((cur.busy || q.size() != 0) && w < 200) begin
      @(posedge ck); #1;
      w++;
    end
    if (w >= 200) failNow("idle_wait");
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int               done_n, start_n, nd;
    logic             tmo;
    logic [CNT_W-1:0] mm;
    logic [L-1:0]     bits;
    bit               dseen;
    int               r;

    repeat (3) @(posedge ck);
    #2 arst = 1'b0;
    @(negedge ck);
    checkOutput("rst_req_ready", req_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_start", bus.start, 0);
    checkOutput("rst_data", bus.data, 0);
    checkOutput("rst_done", rsp_done, 0);

    $display("[TB] scenario 1: clean echo of A5");
    applyStimulus(8'hA5, 1, '0, 0, done_n, tmo, mm, start_n, bits, dseen);
    checkOutput("s1_done_cycle", done_n, 12);
    checkOutput("s1_bits", bits, 8'hA5);
    checkOutput("s1_timeout", tmo, 0);
    checkOutput("s1_mismatch", mm, 0);

    $display("[TB] scenario 2: ready never returned");
    applyStimulus(8'hFF, 0, '0, 0, done_n, tmo, mm, start_n, bits, dseen);
    checkOutput("s2_done_cycle", done_n, 17);
    checkOutput("s2_start_cycles", start_n, 16);
    checkOutput("s2_timeout", tmo, 1);
    checkOutput("s2_mismatch", mm, 0);
    checkOutput("s2_no_data", dseen, 0);

    $display("[TB] scenario 3: bits 2 and 5 corrupted");
    applyStimulus(8'hFF, 1, 8'h24, 0, done_n, tmo, mm, start_n, bits, dseen);
    checkOutput("s3_done_cycle", done_n, 12);
    checkOutput("s3_timeout", tmo, 0);
    checkOutput("s3_mismatch", mm, 2);

    @(posedge ck); #1;
`ifdef MYBUS_INIT_STATS_EN
    checkOutput("s6_bursts", stat_bursts, 3);
    checkOutput("s6_errs", stat_errs, 2);
`else
    checkOutput("s6_bursts", stat_bursts, 0);
    checkOutput("s6_errs", stat_errs, 0);
`endif

    $display("[TB] scenario 5: request held through burst");
    applyStimulus(8'h96, 1, '0, 1, done_n, tmo, mm, start_n, bits, dseen);
    checkOutput("s5_done_cycle", done_n, 12);
    @(posedge ck); #1;
    @(negedge ck);
    checkOutput("s5_idle_ready", req_ready, 1);
    checkOutput("s5_idle_busy", busy, 0);
    @(posedge ck); #1;
    req_valid = 1'b0;
    @(negedge ck);
    checkOutput("s5_second_accept", busy, 1);
    waitIdle();

    $display("[TB] scenario 4: reset during bit 4");
    @(posedge ck); #1;
    req_data = 8'hF0; resp_d = 1; flip_mask = '0; req_valid = 1'b1;
    @(posedge ck); #1;
    req_valid = 1'b0;
    repeat (6) @(posedge ck);
    @(negedge ck); #2;
    arst = 1'b1;
    #1;
    checkOutput("s4_start", bus.start, 0);
    checkOutput("s4_data", bus.data, 0);
    checkOutput("s4_busy", busy, 0);
    @(posedge ck); #2;
    arst = 1'b0;
    nd = 0;
    repeat (15) begin
      @(negedge ck);
      if (rsp_done) nd++;
    end
    checkOutput("s4_no_done", nd, 0);
    applyStimulus(8'h3C, 1, '0, 0, done_n, tmo, mm, start_n, bits, dseen);
    checkOutput("s4_done_cycle", done_n, 12);
    checkOutput("s4_bits", bits, 8'h3C);
    checkOutput("s4_mismatch", mm, 0);
    checkOutput("s4_timeout", tmo, 0);

    $display("[TB] random bursts");
    waitIdle();
    for (int b = 0; b < 80; b++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge ck); #1;
        req_data = L'($urandom);
      end
      @(posedge ck); #1;
      r = $urandom_range(0, 9);
      if (r <= 4) resp_d = 1;
      else if (r <= 6) resp_d = $urandom_range(2, 15);
      else if (r == 7) resp_d = 15;
      else if (r == 8) resp_d = $urandom_range(16, 17);
      else resp_d = 0;
      flip_mask = ($urandom_range(0, 2) == 0) ? L'($urandom) : '0;
      req_data = L'($urandom);
      req_valid = 1'b1;
      @(posedge ck); #1;
      for (int w = 0; w < 100 && (cur.busy || q.size() != 0); w++) begin
        if (q.size() > 2) begin
          req_valid = 1'($urandom);
          req_data = L'($urandom);
        end else begin
          req_valid = 1'b0;
        end
        @(posedge ck); #1;
      end
      req_valid = 1'b0;
      waitIdle();
    end

    repeat (2) @(posedge ck);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
